serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per cycle, LSB first, using full-subtractor logic (the inverse of the team's full-adder cell). Sits beside the arithmetic primitives as an area-lean datapath unit. It has a start/busy command side and a valid/ready result side so it can be chained behind a sequencer or in front of a consumer that may stall.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 2 to 32.
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepted `start`.
- `b`  input  WIDTH  subtrahend; captured on the accepted `start`.
- `busy`  output  1  high in SHIFT and DONE.
- `valid`  output  1  result available; high only in DONE.
- `ready`  input  1  consumer accepts the result.
- `diff`  output  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  output  1  final borrow-out; equals unsigned `a < b`.
- `overflow`  output  1  signed overflow of `a - b`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. Reset enters IDLE.
- **IDLE, with `start` = 1:**
  - load shift registers `sa <= a` and `sb <= b`;
  - capture `a[WIDTH-1]` and `b[WIDTH-1]`;
  - clear the running borrow `bin`, the bit counter and `diff`;
  - go to SHIFT.
- **SHIFT, every cycle:**
  - compute `d = sa[0] ^ sb[0] ^ bin`;
  - compute `bout = (~sa[0] & sb[0]) | (~sa[0] & bin) | (sb[0] & bin)`;
  - shift `d` into `diff` at the MSB, shifting `diff` right;
  - shift `sa` and `sb` right and set `bin <= bout`;
  - increment the counter.
- **End of SHIFT:** on the WIDTH-th SHIFT cycle:
  - `borrow <= bout`;
  - `overflow <= (a_msb != b_msb) && (d != a_msb)`, where `d` is the result MSB;
  - go to DONE.
- **DONE:**
  - `valid` = 1; `diff`, `borrow` and `overflow` are held stable;
  - on `valid && ready`, go to IDLE on the next edge.
- `start` is ignored outside IDLE and causes no queuing.
- The counter width is clog2(WIDTH)+1. There is no wrap: the counter terminates at WIDTH.
- `diff`, `borrow` and `overflow` are meaningful only while `valid` = 1. They hold their last values in IDLE until the next accepted `start`.

## Timing
- **Reset:**
  - all outputs are 0: `busy` = 0, `valid` = 0, `diff` = 0, `borrow` = 0, `overflow` = 0;
  - state is IDLE;
  - assertion takes effect immediately, asynchronously;
  - release is observed at the next rising edge.
- **Start:** `start` is sampled at edge E0; `busy` rises after E0.
- **Latency:**
  - edges E1..E(WIDTH) process bits 0..WIDTH-1;
  - `valid` rises after E(WIDTH), so the result appears WIDTH cycles after the start edge.
- **Handshake:**
  - the transfer completes on the edge where `valid` and `ready` are both 1;
  - `valid` and `busy` drop after that edge;
  - the earliest next `start` is sampled one edge later, giving a throughput of WIDTH+2 cycles per operation.
- **`ready` held high in advance:** the result is accepted on the first DONE cycle, after edge E(WIDTH+1).
- **`start` and `ready` both high in DONE:** the handshake completes and `start` is dropped. The requester must re-assert `start` in IDLE.
- **Reset mid-SHIFT or mid-DONE:** the operation is aborted and there is no partial `valid`.
- **Operand changes:** changes to `a` and `b` after E0 have no effect on the result.

## Test plan
- **Basic subtract:** WIDTH=8, a=100, b=37, `ready`=1 -> `diff`=63, `borrow`=0, `overflow`=0. `valid` rises exactly 8 cycles after the start edge and lasts 1 cycle.
- **Borrow out:** a=5, b=9 -> `diff`=0xFC, `borrow`=1, `overflow`=0.
- **Signed overflow:**
  - a=0x80, b=0x01 -> `diff`=0x7F, `borrow`=0, `overflow`=1;
  - a=0x7F, b=0xFF -> `diff`=0x80, `borrow`=1, `overflow`=1.
- **Back-pressure:** a=0x55, b=0x55, `ready` low for 5 cycles in DONE, with `start` pulsed and `a`/`b` changed meanwhile.
  - `diff`=0x00, `borrow`=0 and `overflow`=0, all stable.
  - `valid` stays high and the extra start is ignored.
  - After `ready`=1: `valid`=0 the next cycle and state is IDLE.
- **Reset mid-operation:** assert `rst_n`=0 on the 3rd SHIFT cycle of a=200, b=1.
  - All outputs are 0 immediately.
  - After release, a=200, b=1 completes normally with `diff`=199.
- **Random sweep:** 1000 random a/b pairs for WIDTH=8 and WIDTH=16 with random `ready` stalls. Each result is compared against the reference `a - b`, unsigned `a < b`, and the signed-overflow model.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Command/result bundle for serial_subtractor: start/busy request side plus
// valid/ready result side carrying diff, borrow and overflow.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output start, a, b, ready,
    input  busy, valid, diff, borrow, overflow
  );

  modport slave (
    input  start, a, b, ready,
    output busy, valid, diff, borrow, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), one bit per cycle,
// LSB first, with start/busy command and valid/ready result handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n, diff_q, diff_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             bin, bin_n;
  logic             a_msb, a_msb_n, b_msb, b_msb_n;
  logic             borrow_q, borrow_n, ovf_q, ovf_n;
  logic             busy_q, busy_n, valid_q, valid_n;
  logic             d_c, bout_c;

  // Full-subtractor cell on the current LSBs.
  assign d_c    = sa[0] ^ sb[0] ^ bin;
  assign bout_c = (~sa[0] & sb[0]) | (~sa[0] & bin) | (sb[0] & bin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      diff_q   <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_n;
      sa       <= sa_n;
      sb       <= sb_n;
      diff_q   <= diff_n;
      cnt      <= cnt_n;
      bin      <= bin_n;
      a_msb    <= a_msb_n;
      b_msb    <= b_msb_n;
      borrow_q <= borrow_n;
      ovf_q    <= ovf_n;
      busy_q   <= busy_n;
      valid_q  <= valid_n;
    end
  end

  // Next-state and datapath update; busy/valid are registered from the next state.
  always_comb begin
    state_n  = state;
    sa_n     = sa;
    sb_n     = sb;
    diff_n   = diff_q;
    cnt_n    = cnt;
    bin_n    = bin;
    a_msb_n  = a_msb;
    b_msb_n  = b_msb;
    borrow_n = borrow_q;
    ovf_n    = ovf_q;
    busy_n   = busy_q;
    valid_n  = valid_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          a_msb_n = bus.a[WIDTH-1];
          b_msb_n = bus.b[WIDTH-1];
          bin_n   = 1'b0;
          cnt_n   = '0;
          diff_n  = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        diff_n = {d_c, diff_q[WIDTH-1:1]};
        sa_n   = sa >> 1;
        sb_n   = sb >> 1;
        bin_n  = bout_c;
        cnt_n  = cnt + CW'(1);
        if (cnt == LAST) begin
          borrow_n = bout_c;
          ovf_n    = (a_msb != b_msb) && (d_c != a_msb);
          valid_n  = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        if (bus.ready) begin
          valid_n = 1'b0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases on an 8-bit unit,
// randomized sweeps on 8- and 16-bit units against an arithmetic model.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  if8();
  serial_subtractor_if #(.WIDTH(16)) if16();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: modular difference, unsigned borrow, signed range overflow.
  function automatic void ref_sub(input int w, input longint unsigned a, input longint unsigned b,
                                  output longint unsigned d, output bit bo, output bit ov);
    longint unsigned m;
    longint          sa, sb, sd;
    m  = 64'd1 << w;
    d  = (a + m - b) % m;
    bo = (a < b);
    sa = (a >= m / 2) ? longint'(a) - longint'(m) : longint'(a);
    sb = (b >= m / 2) ? longint'(b) - longint'(m) : longint'(b);
    sd = sa - sb;
    ov = (sd < -longint'(m / 2)) || (sd > longint'(m / 2) - 1);
  endfunction

  // Issue one 8-bit operation and wait (bounded) for valid; returns cycles after the start edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int cycles);
    if8.a     = a;
    if8.b     = b;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    cycles = 0;
    while (!if8.valid && cycles < 64) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({if8.busy, if8.valid, if8.borrow, if8.overflow, if8.diff} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b valid=%b borrow=%b ovf=%b diff=%h, want all 0",
               if8.busy, if8.valid, if8.borrow, if8.overflow, if8.diff);
    end
    n_cmp++;
    if ({if16.busy, if16.valid, if16.borrow, if16.overflow, if16.diff} !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset16: got busy=%b valid=%b diff=%h, want all 0",
               if16.busy, if16.valid, if16.diff);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (if8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b want 0", if8.busy);
    end
  endtask

  task automatic test_basic;
    int cyc;
    if8.ready = 1'b1;
    op8(8'd100, 8'd37, cyc);
    n_cmp++;
    if (cyc !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    n_cmp++;
    if ({if8.diff, if8.borrow, if8.overflow} !== {8'd63, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got diff=%0d b=%b o=%b want 63 0 0", if8.diff, if8.borrow, if8.overflow);
    end
    n_cmp++;
    if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", if8.busy); end
    tick();
    n_cmp++;
    if ({if8.valid, if8.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_one_cycle: valid=%b busy=%b want 0 0", if8.valid, if8.busy);
    end
  endtask

  task automatic test_borrow;
    int cyc;
    if8.ready = 1'b1;
    op8(8'd5, 8'd9, cyc);
    n_cmp++;
    if ({if8.diff, if8.borrow, if8.overflow} !== {8'hFC, 1'b1, 1'b0} || cyc !== 8) begin
      n_fail++;
      $display("FAIL borrow: got diff=%h b=%b o=%b cyc=%0d want fc 1 0 8",
               if8.diff, if8.borrow, if8.overflow, cyc);
    end
    tick();
  endtask

  task automatic test_overflow;
    int cyc;
    if8.ready = 1'b1;
    op8(8'h80, 8'h01, cyc);
    n_cmp++;
    if ({if8.diff, if8.borrow, if8.overflow} !== {8'h7F, 1'b0, 1'b1} || cyc !== 8) begin
      n_fail++;
      $display("FAIL ovf_neg: got diff=%h b=%b o=%b want 7f 0 1", if8.diff, if8.borrow, if8.overflow);
    end
    tick();
    op8(8'h7F, 8'hFF, cyc);
    n_cmp++;
    if ({if8.diff, if8.borrow, if8.overflow} !== {8'h80, 1'b1, 1'b1} || cyc !== 8) begin
      n_fail++;
      $display("FAIL ovf_pos: got diff=%h b=%b o=%b want 80 1 1", if8.diff, if8.borrow, if8.overflow);
    end
    tick();
  endtask

  task automatic test_back_pressure;
    int cyc;
    if8.ready = 1'b0;
    op8(8'h55, 8'h55, cyc);
    n_cmp++;
    if (cyc !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", cyc); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({if8.valid, if8.busy, if8.diff, if8.borrow, if8.overflow} !== {2'b11, 8'h00, 2'b00}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b busy=%b diff=%h b=%b o=%b want 1 1 00 0 0",
                 i, if8.valid, if8.busy, if8.diff, if8.borrow, if8.overflow);
      end
      if8.start = (i % 2 == 0);
      if8.a     = 8'($urandom);
      if8.b     = 8'($urandom);
      tick();
    end
    if8.start = 1'b0;
    n_cmp++;
    if ({if8.valid, if8.diff} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_still_valid: valid=%b diff=%h want 1 00", if8.valid, if8.diff);
    end
    if8.ready = 1'b1;
    tick();
    n_cmp++;
    if ({if8.valid, if8.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b busy=%b want 0 0", if8.valid, if8.busy);
    end
    if8.ready = 1'b0;
    tick();
    n_cmp++;
    if ({if8.busy, if8.diff} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL bp_no_queue: busy=%b diff=%h want 0 00", if8.busy, if8.diff);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    if8.ready = 1'b1;
    if8.a     = 8'd200;
    if8.b     = 8'd1;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (if8.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", if8.busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if8.busy, if8.valid, if8.borrow, if8.overflow, if8.diff} !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b valid=%b diff=%h want all 0", if8.busy, if8.valid, if8.diff);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({if8.busy, if8.valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_after: busy=%b valid=%b want 0 0", if8.busy, if8.valid);
    end
    op8(8'd200, 8'd1, cyc);
    n_cmp++;
    if ({if8.diff, if8.borrow, if8.overflow} !== {8'd199, 1'b0, 1'b0} || cyc !== 8) begin
      n_fail++;
      $display("FAIL mid_rerun: got diff=%0d b=%b o=%b cyc=%0d want 199 0 0 8",
               if8.diff, if8.borrow, if8.overflow, cyc);
    end
    tick();
    if8.ready = 1'b0;
  endtask

  task automatic test_random_w8;
    logic [7:0] ra, rb;
    longint unsigned ed;
    bit eb, eo;
    int k, cyc;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      k  = int'($urandom_range(0, 3));
      ref_sub(8, 64'(ra), 64'(rb), ed, eb, eo);
      if8.ready = (k == 0);
      op8(ra, rb, cyc);
      n_cmp++;
      if (cyc !== 8) begin n_fail++; $display("FAIL rnd8_latency[%0d]: got %0d want 8", i, cyc); end
      repeat (k) begin
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        tick();
      end
      n_cmp++;
      if ({if8.valid, if8.diff, if8.borrow, if8.overflow} !== {1'b1, 8'(ed), eb, eo}) begin
        n_fail++;
        $display("FAIL rnd8[%0d] a=%h b=%h: got v=%b d=%h b=%b o=%b want 1 %h %b %b",
                 i, ra, rb, if8.valid, if8.diff, if8.borrow, if8.overflow, 8'(ed), eb, eo);
      end
      if8.ready = 1'b1;
      tick();
      if8.ready = 1'b0;
    end
  endtask

  task automatic test_random_w16;
    logic [15:0] ra, rb;
    longint unsigned ed;
    bit eb, eo;
    int k, cyc;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      k  = int'($urandom_range(0, 3));
      ref_sub(16, 64'(ra), 64'(rb), ed, eb, eo);
      if16.ready = (k == 0);
      if16.a     = ra;
      if16.b     = rb;
      if16.start = 1'b1;
      tick();
      if16.start = 1'b0;
      if16.a     = 16'($urandom);
      if16.b     = 16'($urandom);
      cyc = 0;
      while (!if16.valid && cyc < 64) begin
        tick();
        cyc++;
      end
      n_cmp++;
      if (cyc !== 16) begin n_fail++; $display("FAIL rnd16_latency[%0d]: got %0d want 16", i, cyc); end
      repeat (k) tick();
      n_cmp++;
      if ({if16.valid, if16.diff, if16.borrow, if16.overflow} !== {1'b1, 16'(ed), eb, eo}) begin
        n_fail++;
        $display("FAIL rnd16[%0d] a=%h b=%h: got v=%b d=%h b=%b o=%b want 1 %h %b %b",
                 i, ra, rb, if16.valid, if16.diff, if16.borrow, if16.overflow, 16'(ed), eb, eo);
      end
      if16.ready = 1'b1;
      tick();
      if16.ready = 1'b0;
    end
  endtask

  initial begin
    if8.start  = 1'b0;
    if8.a      = '0;
    if8.b      = '0;
    if8.ready  = 1'b0;
    if16.start = 1'b0;
    if16.a     = '0;
    if16.b     = '0;
    if16.ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_back_pressure();
    test_reset_mid();
    test_random_w8();
    test_random_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
